// File: rtl/rf_wr_arbiter_if.sv
// Register-file write arbiter bus: requester handshakes, stall input and the
// registered write port toward the register file.
// Optional macro RF_ARB_LOCK_EN adds the per-requester req_lock signal.
interface rf_wr_arbiter_if #(
    parameter int NUM_REQ = 2,
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 3
);
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        req_ready;
`ifdef RF_ARB_LOCK_EN
    logic [NUM_REQ-1:0]        req_lock;
`endif
    logic                      rf_stall;
    logic                      rf_wr_en;
    logic [ADDR_W-1:0]         rf_wr_addr;
    logic [DATA_W-1:0]         rf_wr_data;
    logic                      busy;

`ifdef RF_ARB_LOCK_EN
    // Requesters plus register-file side (drives requests and stall).
    modport master (
        output req_valid, req_addr, req_data, req_lock, rf_stall,
        input  req_ready, rf_wr_en, rf_wr_addr, rf_wr_data, busy
    );
    // Arbiter side.
    modport slave (
        input  req_valid, req_addr, req_data, req_lock, rf_stall,
        output req_ready, rf_wr_en, rf_wr_addr, rf_wr_data, busy
    );
`else
    // Requesters plus register-file side (drives requests and stall).
    modport master (
        output req_valid, req_addr, req_data, rf_stall,
        input  req_ready, rf_wr_en, rf_wr_addr, rf_wr_data, busy
    );
    // Arbiter side.
    modport slave (
        input  req_valid, req_addr, req_data, rf_stall,
        output req_ready, rf_wr_en, rf_wr_addr, rf_wr_data, busy
    );
`endif
endinterface

// File: rtl/rf_wr_arbiter.sv
// rf_wr_arbiter: round-robin arbiter sharing one register-file write port
// among NUM_REQ (2..4) writeback requesters. The grant is combinational in the
// request cycle; the winning write is registered once and presented on rf_*
// in the following cycle, sustaining one write per cycle.
// Optional macro RF_ARB_LOCK_EN: a requester transferring with req_lock=1
// keeps exclusive ownership of the port until it transfers with req_lock=0.
module rf_wr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 3
) (
    input logic           clk,
    input logic           rst,
    rf_wr_arbiter_if.slave bus
);

    // Pointer wide enough to index up to four requesters.
    localparam int PTR_W = (NUM_REQ > 2) ? 2 : 1;

    typedef logic [PTR_W-1:0] idx_t;

    // Next requester index after i, wrapping at NUM_REQ.
    function automatic idx_t wrap_inc(input idx_t i);
        logic [PTR_W:0] s;
        s = {1'b0, i} + (PTR_W+1)'(1);
        if (s >= (PTR_W+1)'(NUM_REQ)) begin
            s = '0;
        end
        return s[PTR_W-1:0];
    endfunction

    // First candidate found searching start, start+1, ... modulo NUM_REQ.
    function automatic logic [NUM_REQ-1:0] rr_pick(
        input logic [NUM_REQ-1:0] cand,
        input idx_t               start
    );
        logic [NUM_REQ-1:0] pick;
        idx_t               idx;
        logic               found;
        pick  = '0;
        idx   = start;
        found = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!found && cand[idx]) begin
                pick[idx] = 1'b1;
                found     = 1'b1;
            end
            idx = wrap_inc(idx);
        end
        return pick;
    endfunction

    idx_t               ptr_q, ptr_d;
    logic [NUM_REQ-1:0] cand;
    logic [NUM_REQ-1:0] grant;
    idx_t               win;
    logic               xfer;
    logic               ptr_upd;
    logic [ADDR_W-1:0]  win_addr;
    logic [DATA_W-1:0]  win_data;

    logic               wr_en_q;
    logic [ADDR_W-1:0]  wr_addr_q;
    logic [DATA_W-1:0]  wr_data_q;

`ifdef RF_ARB_LOCK_EN
    typedef enum logic {
        ST_ARB,
        ST_LOCKED
    } state_t;

    state_t state_q, state_d;
    idx_t   owner_q, owner_d;

    // Lock state register; reset always returns to open arbitration.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_ARB;
            owner_q <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
        end
    end

    // Lock next-state: enter on a locked transfer, leave on an unlocked one
    // from the owner.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves a variable unassigned, which would infer a latch.
        state_d = state_q;
        owner_d = owner_q;
        unique case (state_q)
            ST_ARB: begin
                if (xfer && bus.req_lock[win]) begin
                    state_d = ST_LOCKED;
                    owner_d = win;
                end
            end
            ST_LOCKED: begin
                if (xfer && !bus.req_lock[win]) begin
                    state_d = ST_ARB;
                end
            end
            default: state_d = ST_ARB;
        endcase
    end

    // Candidates: only the owner while locked; pointer frozen until the
    // owner's unlocking transfer.
    always_comb begin
        cand    = bus.req_valid;
        ptr_upd = xfer;
        if (state_q == ST_LOCKED) begin
            cand    = bus.req_valid & (NUM_REQ'(1) << owner_q);
            ptr_upd = xfer && !bus.req_lock[win];
        end
    end
`else
    // Candidates: every valid requester; pointer advances on each transfer.
    always_comb begin
        cand    = bus.req_valid;
        ptr_upd = xfer;
    end
`endif

    // Same-cycle one-hot grant, suppressed during stall and reset.
    always_comb begin
        grant = '0;
        if (rst && !bus.rf_stall) begin
            grant = rr_pick(cand, ptr_q);
        end
    end

    // Winner index and its write fields.
    always_comb begin
        win      = '0;
        win_addr = '0;
        win_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                win      = idx_t'(i);
                win_addr = bus.req_addr[i*ADDR_W +: ADDR_W];
                win_data = bus.req_data[i*DATA_W +: DATA_W];
            end
        end
        xfer = |grant;
    end

    // Round-robin pointer next value: one past the last winner.
    always_comb begin
        ptr_d = ptr_q;
        if (ptr_upd) begin
            ptr_d = wrap_inc(win);
        end
    end

    // Round-robin pointer register; requester 0 has priority after reset.
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of block order.
        if (!rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    // Registered write port; addr/data hold when no transfer happens.
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: the datapath registers are reset too, so a write pending at
        // reset is dropped and rf_wr_addr/rf_wr_data read as zero.
        if (!rst) begin
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            wr_en_q <= xfer;
            if (xfer) begin
                wr_addr_q <= win_addr;
                wr_data_q <= win_data;
            end
        end
    end

    assign bus.req_ready  = grant;
    assign bus.rf_wr_en   = wr_en_q;
    assign bus.rf_wr_addr = wr_addr_q;
    assign bus.rf_wr_data = wr_data_q;
    assign bus.busy       = wr_en_q | (|bus.req_valid);

endmodule
